sr_bank: RTL and testbench
==========================

Name: sr_bank

Overview:
- Multi-channel, parametrised successor to the single serial shift register.
- NCH independent shift channels, each WIDTH bits, share one shift engine: programmable shift length, direction, loopback, clock divider and a done interrupt.
- Programmed over the same valid/wstrb/ready slave handshake used by the user-project wrapper, which instantiates the block.

Parameters:
- WIDTH, 32, bits per channel (1..32).
- NCH, 4, number of channels (1..12).
- ADDR_W, 4, word-address width; must satisfy 4+NCH <= 2**ADDR_W.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  bus request; held until ready.
- addr  in  ADDR_W  word address.
- wstrb  in  4  byte write strobes; all zero means read.
- wdata  in  32  write data.
- rdata  out  32  read data; valid while ready=1.
- ready  out  1  one-cycle acknowledge.
- sin  in  NCH  serial input per channel.
- sout  out  NCH  serial output per channel.
- irq  out  1  level interrupt = done & irq_en.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: [0] start (W1, self-clearing), [1] dir (0 = shift toward MSB, LSB fill; 1 = toward LSB, MSB fill), [2] loop (channel's own sout replaces sin), [3] irq_en, [4] abort (W1, self-clearing).
  - 1 STATUS (RO except done): [0] busy, [1] done (sticky, write-1-to-clear), [15:8] remaining count.
  - 2 LEN: [5:0] shift count.
  - 3 DIV: [7:0] shift every DIV+1 cycles.
  - 4+i DATA[i]: channel i contents, LSB-aligned, upper bits read 0.
  - Unmapped addresses: reads return 0, writes are ignored.
- Byte lanes: writes honour wstrb per byte.
- Handshake:
  - ready rises the cycle after valid is sampled high, for exactly one cycle.
  - A new request is sampled no earlier than the cycle after ready.
  - rdata is registered and is 0 when ready=0.
- sout[i] = DATA[i][WIDTH-1] if dir=0, else DATA[i][0]; combinational from the register.
- Reset values: all registers 0; ready=0, rdata=0, irq=0, busy=0; state IDLE; sout=0.
- FSM:
  - IDLE: on a start write:
    - LEN=0: go to DONE, no shift.
    - LEN>WIDTH: clamp cnt to WIDTH.
    - Otherwise load cnt=LEN, divcnt=DIV, go to SHIFT.
    - busy=1 from the cycle after the ack.
  - SHIFT: when divcnt=0, all channels shift one bit simultaneously, cnt decrements and divcnt reloads DIV; otherwise divcnt decrements. The shift that takes cnt to 0 moves the FSM to DONE.
  - DONE: one cycle; set done, clear busy, return to IDLE.
- Timing at DIV=0, LEN=N: shifts occur on N consecutive cycles beginning two cycles after the start ack, and done is set one cycle after the last shift.
- While busy:
  - Writes to DATA, LEN and DIV are acked but ignored.
  - A start write is ignored.
  - A write to CTRL irq_en/dir/loop updates irq_en only; dir and loop are frozen for the operation.
  - An abort write returns to IDLE the next cycle with partial data kept and done not set.
- Same-cycle conflicts:
  - A done set coinciding with a W1C clear of done: set wins.
  - Reset mid-shift clears all state immediately (asynchronous).

Decomposition:
- Shared package sr_pkg holds:
  - Register offset localparams (CTRL=0, STATUS=1, LEN=2, DIV=3, DATA_BASE=4).
  - CTRL bit indices.
  - FSM state enum {IDLE, SHIFT, DONE}.
- One natural sub-module, sr_chan: a single WIDTH-bit shift register with load, shift-enable, dir, serial in and serial out, instantiated NCH times by a generate loop.
- Bus decode and FSM stay in sr_bank.

Test Plan:
- Reset, then read every register: all read 0, ready pulses exactly one cycle after valid, sout=0.
- Write DATA[0]=0x8000_0001, LEN=4, DIV=0, dir=0, sin[0]=1, then start: sout[0] reads 1 before the first shift; after done, DATA[0]=0x0000_001F and STATUS done=1.
- Set loop=1, dir=1, LEN=32, DATA[1]=0xA5A5_1234, then start: after done, DATA[1]=0xA5A5_1234 (full rotation).
- Set DIV=3, LEN=2, then start: done is set exactly 1+2×4 cycles after the first shift slot, and busy is high throughout.
- Start with LEN=8, abort after 3 shifts: busy=0, done=0, DATA shifted by exactly 3; a write to DATA issued mid-shift has no effect.
- Set irq_en=1 and start with LEN=0: done=1 and irq=1 two cycles after the ack. W1C done: irq=0. Assert reset_n low mid-shift: all state returns to its reset values.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the multi-channel shift-register bank: register map,
// CTRL/STATUS bit positions, engine states and a byte-lane merge helper.
package sr_pkg;

  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_STATUS    = 1;
  localparam int unsigned REG_LEN       = 2;
  localparam int unsigned REG_DIV       = 3;
  localparam int unsigned REG_DATA_BASE = 4;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_LOOP   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned CTRL_ABORT  = 4;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sr_state_e;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sr_chan.sv
// One WIDTH-bit shift channel: parallel load, single-bit shift in either
// direction, serial output taken from the bit about to leave.
module sr_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic             sin_i,
  output logic             sout_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_shifted;

  generate
    if (WIDTH == 1) begin : g_w1
      assign data_shifted = sin_i;
    end else begin : g_wn
      assign data_shifted = dir_i ? {sin_i, data_q[WIDTH-1:1]}
                                  : {data_q[WIDTH-2:0], sin_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= data_shifted;
    end
  end

  assign sout_o = dir_i ? data_q[0] : data_q[WIDTH-1];
  assign data_o = data_q;

endmodule

// File: rtl/sr_bank.sv
// NCH shift channels driven by one shared shift engine, programmed through a
// valid/wstrb/ready register slave with a registered one-cycle acknowledge.
module sr_bank
  import sr_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NCH    = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  input  logic [NCH-1:0]    sin,
  output logic [NCH-1:0]    sout,
  output logic              irq
);

  localparam logic [5:0] WIDTH_CNT = 6'(WIDTH);

  sr_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  divcnt_q, divcnt_d;
  logic        shift_en;
  logic        done_set;

  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, abort_q, done_q;
  logic        irq_en_q, dir_q, loop_q;
  logic [5:0]  len_q;
  logic [7:0]  div_q;

  logic [WIDTH-1:0] chan_data [NCH];

  logic accept, wr_acc, rd_acc, ctrl_wr, busy, busy_ops;

  // A request is never sampled during its own acknowledge cycle.
  assign accept   = valid & ~ready_q;
  assign wr_acc   = accept & (|wstrb);
  assign rd_acc   = accept & ~(|wstrb);
  assign ctrl_wr  = wr_acc & wstrb[0] & (addr == ADDR_W'(REG_CTRL));
  assign busy     = (state_q != IDLE);
  assign busy_ops = busy | start_q;

  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      if (addr == ADDR_W'(REG_CTRL))
        rdata_d = {27'd0, 1'b0, irq_en_q, loop_q, dir_q, 1'b0};
      else if (addr == ADDR_W'(REG_STATUS))
        rdata_d = {16'd0, 2'd0, cnt_q, 6'd0, done_q, busy};
      else if (addr == ADDR_W'(REG_LEN))
        rdata_d = {26'd0, len_q};
      else if (addr == ADDR_W'(REG_DIV))
        rdata_d = {24'd0, div_q};
      for (int i = 0; i < NCH; i++) begin
        if (addr == ADDR_W'(REG_DATA_BASE + i)) rdata_d = 32'(chan_data[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      dir_q    <= 1'b0;
      loop_q   <= 1'b0;
      len_q    <= '0;
      div_q    <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= rdata_d;
      start_q <= ctrl_wr & wdata[CTRL_START] & (state_q == IDLE) & ~start_q;
      abort_q <= ctrl_wr & wdata[CTRL_ABORT] & (state_q == SHIFT);
      if (ctrl_wr) irq_en_q <= wdata[CTRL_IRQ_EN];
      // dir/loop stay frozen for the whole operation.
      if (ctrl_wr && !busy_ops) begin
        dir_q  <= wdata[CTRL_DIR];
        loop_q <= wdata[CTRL_LOOP];
      end
      if (wr_acc && wstrb[0] && !busy_ops && addr == ADDR_W'(REG_LEN))
        len_q <= wdata[5:0];
      if (wr_acc && wstrb[0] && !busy_ops && addr == ADDR_W'(REG_DIV))
        div_q <= wdata[7:0];
      // Completion outranks a simultaneous write-1-to-clear.
      if (done_set)
        done_q <= 1'b1;
      else if (wr_acc && wstrb[0] && wdata[STAT_DONE] && addr == ADDR_W'(REG_STATUS))
        done_q <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    divcnt_d = divcnt_q;
    shift_en = 1'b0;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          if (len_q == 6'd0) begin
            state_d = DONE;
          end else begin
            cnt_d    = (len_q > WIDTH_CNT) ? WIDTH_CNT : len_q;
            divcnt_d = div_q;
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (divcnt_q == 8'd0) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - 6'd1;
          divcnt_d = div_q;
          if (cnt_q == 6'd1) state_d = DONE;
        end else begin
          divcnt_d = divcnt_q - 8'd1;
        end
      end
      DONE: begin
        done_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      divcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      divcnt_q <= divcnt_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sin_eff;

    assign load     = wr_acc & ~busy_ops & (addr == ADDR_W'(REG_DATA_BASE + gi));
    assign load_val = WIDTH'(byte_merge(32'(chan_data[gi]), wdata, wstrb));
    assign sin_eff  = loop_q ? sout[gi] : sin[gi];

    sr_chan #(.WIDTH(WIDTH)) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (load),
      .load_data_i (load_val),
      .shift_i     (shift_en),
      .dir_i       (dir_q),
      .sin_i       (sin_eff),
      .sout_o      (sout[gi]),
      .data_o      (chan_data[gi])
    );
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign irq   = done_q & irq_en_q;

endmodule

// File: tb/tb_sr_bank.sv
// Directed bench for sr_bank: a schedule-based reference model compared every
// cycle, plus hand-computed register expectations for each scenario.
module tb_sr_bank;

  localparam int W      = 32;
  localparam int NCH    = 4;
  localparam int ADDR_W = 4;
  localparam logic [31:0] MASK = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [3:0]        wstrb = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              ready;
  logic [NCH-1:0]    sin = '0;
  logic [NCH-1:0]    sout;
  logic              irq;

  sr_bank #(.WIDTH(W), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sin(sin), .sout(sout), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_rise_cyc = -1;
  bit irq_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ready, m_active, m_busy, m_done, m_dir, m_loop, m_irq_en;
  logic [31:0] m_rdata;
  int          m_k, m_n, m_d, m_cnt, m_abort_edge, m_len, m_div;
  logic [31:0] m_data [NCH];

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return 32'((m_irq_en << 3) | (m_loop << 2) | (m_dir << 1));
    if (ai == 1) return 32'((m_cnt << 8) | (m_done << 1) | m_busy);
    if (ai == 2) return 32'(m_len);
    if (ai == 3) return 32'(m_div);
    if (ai >= 4 && ai < 4 + NCH) return m_data[ai-4];
    return 32'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready = 0; m_rdata = '0; m_active = 0; m_busy = 0; m_done = 0;
      m_dir = 0; m_loop = 0; m_irq_en = 0; m_cnt = 0; m_len = 0; m_div = 0;
      m_k = 0; m_n = 0; m_d = 0; m_abort_edge = -1;
      for (int i = 0; i < NCH; i++) m_data[i] = '0;
    end else begin
      int c, t, ai;
      bit act_pre, acc, do_shift, done_now, abort_now, first;
      logic [31:0] rnext, merged, inb;
      cyc = cyc + 1;
      c = cyc;
      act_pre = m_active;
      acc = valid && !m_ready;
      rnext = (acc && wstrb == 4'd0) ? model_read(addr) : 32'd0;
      do_shift = 0; done_now = 0; abort_now = 0; first = 0; t = 0;
      if (act_pre) begin
        t = c - m_k - 1;
        if (c == m_abort_edge) abort_now = 1;
        else begin
          first = (t == 0);
          do_shift = (m_n > 0) && (t >= 1) && (t % (m_d + 1) == 0) && (t / (m_d + 1) <= m_n);
          done_now = (c == m_k + 2 + (m_d + 1) * m_n);
        end
      end
      if (do_shift) begin
        for (int i = 0; i < NCH; i++) begin
          inb = m_loop ? (m_dir ? {31'd0, m_data[i][0]} : {31'd0, m_data[i][W-1]})
                       : {31'd0, sin[i]};
          if (m_dir) m_data[i] = (m_data[i] >> 1) | (inb << (W - 1));
          else       m_data[i] = ((m_data[i] << 1) | inb) & MASK;
        end
      end
      if (acc && wstrb != 4'd0) begin
        ai = int'(addr);
        if (ai == 0 && wstrb[0]) begin
          m_irq_en = wdata[3];
          if (!act_pre) begin
            m_dir = wdata[1]; m_loop = wdata[2];
          end
          if (wdata[0] && !act_pre) begin
            m_active = 1; m_k = c; m_n = (m_len > W) ? W : m_len; m_d = m_div;
            m_abort_edge = -1;
          end
          if (wdata[4] && act_pre && m_n > 0 && c >= m_k + 2 && c < m_k + 1 + (m_d + 1) * m_n)
            m_abort_edge = c + 1;
        end else if (ai == 1 && wstrb[0] && wdata[1]) begin
          m_done = 0;
        end else if (ai == 2 && wstrb[0] && !act_pre) begin
          m_len = int'(wdata[5:0]);
        end else if (ai == 3 && wstrb[0] && !act_pre) begin
          m_div = int'(wdata[7:0]);
        end else if (ai >= 4 && ai < 4 + NCH && !act_pre) begin
          merged = m_data[ai-4];
          for (int b = 0; b < 4; b++) if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
          m_data[ai-4] = merged & MASK;
        end
      end
      if (abort_now) begin m_active = 0; m_busy = 0; m_cnt = 0; end
      if (first)     begin m_busy = 1; m_cnt = m_n; end
      if (do_shift)  m_cnt = m_n - t / (m_d + 1);
      if (done_now)  begin m_done = 1; m_busy = 0; m_active = 0; m_cnt = 0; end
      m_ready = acc;
      m_rdata = rnext;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NCH-1:0] exp_sout;
    for (int i = 0; i < NCH; i++) exp_sout[i] = m_dir ? m_data[i][0] : m_data[i][W-1];
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("rdata", rdata, m_rdata);
    chk("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
    chk("sout", 32'(sout), 32'(exp_sout));
    if (irq && !irq_prev) irq_rise_cyc = cyc;
    irq_prev = irq;
  end

  // ---------------- bus tasks (called at posedge + 1) ----------------
  task automatic bus(input logic [ADDR_W-1:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r, output int acc_cyc);
    int n;
    bit got;
    valid = 1'b1; addr = a; wstrb = s; wdata = d; n = 0; got = 0;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (ready) got = 1;
    end
    chk("ack_latency", 32'(n), 32'd1);
    acc_cyc = cyc;
    r = rdata;
    valid = 1'b0; wstrb = 4'd0;
    @(posedge clk); #1;
    chk("ack_width", {31'd0, ready}, 32'd0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    logic [31:0] r; int k;
    bus(ADDR_W'(a), 4'hF, d, r, k);
  endtask

  task automatic wr_k(input int a, input logic [31:0] d, output int k);
    logic [31:0] r;
    bus(ADDR_W'(a), 4'hF, d, r, k);
  endtask

  task automatic rd(input int a, output logic [31:0] r);
    int k;
    bus(ADDR_W'(a), 4'h0, 32'd0, r, k);
  endtask

  task automatic rd_expect(input string name, input int a, input logic [31:0] exp);
    logic [31:0] r;
    rd(a, r);
    chk(name, r, exp);
  endtask

  task automatic wait_done();
    logic [31:0] r;
    int n;
    n = 0;
    r = 32'd0;
    while (!r[1] && n < 40) begin
      rd(1, r);
      n++;
    end
    if (!r[1]) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    logic [31:0] r;
    int polls;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state: every register and the unmapped space read 0.
    chk("reset_sout", 32'(sout), 32'd0);
    for (int a = 0; a < 4 + NCH + 1; a++) rd_expect("reset_reg", a, 32'd0);
    rd_expect("unmapped_rd", 15, 32'd0);
    wr(15, 32'hDEAD_BEEF);
    rd_expect("unmapped_wr", 15, 32'd0);

    // Byte lanes on a data register.
    wr(7, 32'h1122_3344);
    begin
      logic [31:0] rr; int kk;
      bus(ADDR_W'(7), 4'b0010, 32'hAABB_CCDD, rr, kk);
    end
    rd_expect("byte_lane", 7, 32'h1122_CC44);

    // Basic shift toward MSB with LSB fill from sin.
    sin = 4'b0001;
    wr(4, 32'h8000_0001);
    wr(2, 4);
    wr(3, 0);
    chk("sout_pre_shift", {31'd0, sout[0]}, 32'd1);
    wr(0, 32'h1);
    wait_done();
    rd_expect("shift_data0", 4, 32'h0000_001F);
    rd_expect("shift_status", 1, 32'h0000_0002);

    // Full rotation via loopback toward LSB.
    sin = 4'b0000;
    wr(1, 32'h2);
    wr(2, 32);
    wr(5, 32'hA5A5_1234);
    wr(0, 32'h7);
    wait_done();
    rd_expect("rotate_data1", 5, 32'hA5A5_1234);
    rd_expect("rotate_data0", 4, 32'h0000_001F);

    // LEN above WIDTH is clamped to one full rotation.
    wr(1, 32'h2);
    wr(2, 63);
    wr(0, 32'h7);
    wait_done();
    rd_expect("clamp_data1", 5, 32'hA5A5_1234);

    // Divider: done 1+2*4 cycles after the shift state is entered.
    wr(1, 32'h2);
    wr(0, 32'h8);
    wr(3, 3);
    wr(2, 2);
    irq_rise_cyc = -1;
    wr_k(0, 32'h9, k);
    polls = 0;
    r = 32'd0;
    while (!r[1] && polls < 20) begin
      rd(1, r);
      polls++;
      if (!r[1]) chk("div_busy", {31'd0, r[0]}, 32'd1);
    end
    chk("div_done_seen", {31'd0, r[1]}, 32'd1);
    chk("div_irq_timing", 32'(irq_rise_cyc - k), 32'd10);

    // Abort after exactly three shifts; mid-shift data write ignored.
    wr(1, 32'h2);
    wr(0, 32'h0);
    wr(3, 0);
    wr(2, 8);
    wr(6, 32'h0000_00FF);
    wr(0, 32'h1);
    wr(6, 32'h1234_5678);
    wr(0, 32'h10);
    rd_expect("abort_status", 1, 32'h0000_0000);
    rd_expect("abort_data2", 6, 32'h0000_07F8);

    // LEN=0 with irq enabled: done and irq two cycles after the ack.
    wr(2, 0);
    wr_k(0, 32'h9, k);
    chk("len0_irq_early", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("len0_irq", {31'd0, irq}, 32'd1);
    rd_expect("len0_status", 1, 32'h0000_0002);
    wr(1, 32'h2);
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // Asynchronous reset in the middle of an operation.
    wr(4, 32'hFFFF_FFFF);
    wr(2, 8);
    wr(0, 32'h9);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 4 + NCH; a++) rd_expect("post_rst_reg", a, 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
